program_memory_loader: RTL and testbench
========================================

Name: program_memory_loader

Overview:
Avalon-MM master that fills the CPU program memory (8192 x 32-bit single-port on-chip RAM, one-cycle read latency, no waitrequest) from a byte stream, such as a UART or JTAG bridge, while the CPU is held frozen. Bytes are packed little-endian into words and written to sequential word addresses from 0. An optional readback pass re-reads every written word and compares a 32-bit additive checksum. The block drives the memory's address, byteenable, chipselect, write and writedata ports and consumes its readdata.

Parameters:
ADDR_WIDTH, 13, word address width of program memory
NUM_WORDS, 8192, memory depth in words
CNT_WIDTH, 14, width of word_count; must hold NUM_WORDS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
word_count  in  CNT_WIDTH  number of words to load; sampled with start
verify_en  in  1  enables the readback pass; sampled with start
in_data  in  8  stream byte
in_valid  in  1  stream byte valid
in_ready  out  1  byte accepted when in_valid & in_ready
address  out  ADDR_WIDTH  memory word address
byteenable  out  4  byte enables
chipselect  out  1  memory access strobe
write  out  1  write strobe (qualified by chipselect)
writedata  out  32  write data
readdata  in  32  memory read data, valid one cycle after a read
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
error  out  1  sticky status, cleared on next accepted start
checksum  out  32  modulo-2^32 sum of written words
words_written  out  CNT_WIDTH  count of words written

Behaviour:
- Reset values: all outputs are 0, except byteenable = 4'hF. State is IDLE and all counters and accumulators are 0.
- States: IDLE, COLLECT, WRITE, VERIFY_RD, VERIFY_WAIT, DONE.
- IDLE:
  - start=1 with 1 <= word_count <= NUM_WORDS: latch word_count and verify_en, clear error, checksum, words_written and the address counter, then go to COLLECT. busy=1 from the next cycle.
  - start=1 with word_count=0 or word_count>NUM_WORDS: set error=1 and go to DONE. No memory access occurs.
- COLLECT:
  - in_ready=1.
  - Each accepted byte fills byte lane k (k=0..3, lane 0 first, i.e. bits [8k+7:8k]).
  - On acceptance of lane 3, go to WRITE.
  - Gaps in in_valid stall indefinitely with no timeout.
- WRITE (exactly one cycle):
  - chipselect=1, write=1, byteenable=4'hF, address=current word index, writedata=assembled word, in_ready=0.
  - Add the word to checksum, increment words_written and the address counter.
  - If words_written reaches word_count: go to VERIFY_RD if verify_en, else DONE. Otherwise go to COLLECT.
  - Latency: lane-3 byte accepted in cycle N gives the write strobe in cycle N+1.
- Verify pass:
  - On entry, the address counter and the verify accumulator are cleared.
  - VERIFY_RD: chipselect=1, write=0, address=index. The next state is VERIFY_WAIT.
  - VERIFY_WAIT: chipselect=0. Add readdata to the verify accumulator and increment the index. Go back to VERIFY_RD until word_count words have been read.
  - After the last word, set error=1 if the verify accumulator != checksum, then go to DONE.
  - Throughput is 2 cycles per word.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- Outside access cycles, chipselect=0 and write=0. address and writedata hold their last value.
- start while busy is ignored. in_data presented while not in COLLECT is not consumed.
- Counters do not wrap: a maximum-length load writes addresses 0..NUM_WORDS-1 exactly once.
- reset asserted mid-operation aborts immediately:
  - All outputs return to reset values; a partial word is discarded.
  - chipselect and write fall asynchronously with reset.
  - No done pulse is produced.

Test Plan:
- word_count=2, verify_en=0, bytes 11,22,...,88 sent back-to-back -> writes 0x44332211 @0 and 0x88776655 @1, each write strobe one cycle after its 4th byte; checksum=0xCCAA8866, words_written=2, done pulse, error=0.
- Same load with verify_en=1 against a one-cycle-latency memory model -> two reads at addresses 0 and 1 spaced 2 cycles apart, error=0.
- Verify with the model corrupting address 1 to 0x88776656 on readback -> error=1, done pulse, error held until the next start.
- word_count=0, then word_count=8193 -> no chipselect; error=1 and done within 2 cycles.
- Random in_valid gaps plus a start pulse mid-load -> same memory contents as the back-to-back case, start ignored, in_ready low during WRITE cycles.
- reset asserted after 6 bytes -> outputs go to reset values at once. A new load of word_count=1, bytes AA,BB,CC,DD then writes 0xDDCCBBAA @0.

Source files
------------

// File: rtl/program_memory_loader.sv
// Streams bytes into the CPU program RAM as little-endian words at addresses 0..N-1,
// with an optional readback pass that compares an additive checksum of what was written.
module program_memory_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int NUM_WORDS  = 8192,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  verify_en,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [3:0]            byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [31:0]           writedata,
  input  logic [31:0]           readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           checksum,
  output logic [CNT_WIDTH-1:0]  words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_VERIFY_RD, S_VERIFY_WAIT, S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(NUM_WORDS);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

  state_t               state, nxt;
  logic [CNT_WIDTH-1:0] target;
  logic                 verify_q;
  logic [1:0]           lane;
  logic [23:0]          word_q;
  logic [CNT_WIDTH-1:0] idx;
  logic [31:0]          vacc;

  logic start_ok, accept, last_wr, last_rd;
  logic [31:0] vacc_nxt;

  assign start_ok = start && (word_count != '0) && (word_count <= MAX_WORDS);
  assign accept   = (state == S_COLLECT) && in_valid;
  assign last_wr  = (words_written + ONE) == target;
  assign last_rd  = (idx + ONE) == target;
  assign vacc_nxt = vacc + readdata;

  assign byteenable = 4'hF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:        if (start) nxt = start_ok ? S_COLLECT : S_DONE;
      S_COLLECT:     if (accept && lane == 2'd3) nxt = S_WRITE;
      S_WRITE:       nxt = !last_wr ? S_COLLECT : (verify_q ? S_VERIFY_RD : S_DONE);
      S_VERIFY_RD:   nxt = S_VERIFY_WAIT;
      S_VERIFY_WAIT: nxt = last_rd ? S_DONE : S_VERIFY_RD;
      S_DONE:        nxt = S_IDLE;
      default:       nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so they drop with reset.
  always_comb begin
    in_ready   = (state == S_COLLECT);
    chipselect = (state == S_WRITE) || (state == S_VERIFY_RD);
    write      = (state == S_WRITE);
    busy       = (state == S_COLLECT) || (state == S_WRITE) ||
                 (state == S_VERIFY_RD) || (state == S_VERIFY_WAIT);
    done       = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target        <= '0;
      verify_q      <= 1'b0;
      lane          <= 2'd0;
      word_q        <= '0;
      idx           <= '0;
      vacc          <= '0;
      address       <= '0;
      writedata     <= '0;
      error         <= 1'b0;
      checksum      <= '0;
      words_written <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            target        <= word_count;
            verify_q      <= verify_en;
            error         <= 1'b0;
            checksum      <= '0;
            words_written <= '0;
            idx           <= '0;
            lane          <= 2'd0;
          end else if (start) begin
            error <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            lane <= lane + 2'd1;
            unique case (lane)
              2'd0: word_q[7:0]   <= in_data;
              2'd1: word_q[15:8]  <= in_data;
              2'd2: word_q[23:16] <= in_data;
              2'd3: begin
                // Final lane goes straight to the bus register for next cycle's write.
                writedata <= {in_data, word_q};
                address   <= idx[ADDR_WIDTH-1:0];
              end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          checksum      <= checksum + writedata;
          words_written <= words_written + ONE;
          idx           <= idx + ONE;
          if (last_wr && verify_q) begin
            idx     <= '0;
            vacc    <= '0;
            address <= '0;
          end
        end
        S_VERIFY_WAIT: begin
          vacc <= vacc_nxt;
          idx  <= idx + ONE;
          if (last_rd) begin
            if (vacc_nxt != checksum) error <= 1'b1;
          end else begin
            address <= ADDR_WIDTH'(idx + ONE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized bench for program_memory_loader: RAM model plus a word/checksum reference
// computed from the byte stream, with write/read logs captured by a bus monitor.
module tb_program_memory_loader;
  localparam int AW = 13;
  localparam int NW = 8192;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] word_count;
  logic          verify_en;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          busy;
  logic          done;
  logic          error;
  logic [31:0]   checksum;
  logic [CW-1:0] words_written;

  always #5 clk = ~clk;

  program_memory_loader #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .verify_en(verify_en), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .byteenable(byteenable), .chipselect(chipselect), .write(write),
    .writedata(writedata), .readdata(readdata), .busy(busy), .done(done), .error(error),
    .checksum(checksum), .words_written(words_written)
  );

  // One-cycle-latency RAM; address 1 can be corrupted (+1) on readback.
  logic [31:0] mem [0:NW-1];
  logic [31:0] rd_q = '0;
  bit          corrupt_en = 1'b0;
  assign readdata = rd_q;
  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write)
      rd_q <= mem[address] + ((corrupt_en && address == AW'(1)) ? 32'd1 : 32'd0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic        wr_rdy_q[$];
  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  int          cs_count = 0;
  always @(negedge clk) begin
    if (chipselect) cs_count++;
    if (chipselect && write) begin
      wr_addr_q.push_back(int'(address));
      wr_data_q.push_back(writedata);
      wr_cyc_q.push_back(cyc);
      wr_rdy_q.push_back(in_ready);
    end
    if (chipselect && !write) begin
      rd_addr_q.push_back(int'(address));
      rd_cyc_q.push_back(cyc);
    end
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pat[$];
  int         acc_q[$];
  int         last_acc;

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g, t;
    if (gaps) begin
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = ($urandom_range(0, 2) == 0);
        word_count = CW'($urandom_range(1, 20));
        verify_en  = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL byte_accept timeout, in_ready=%0b want 1", in_ready);
    end
    last_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_load(input int n, input bit ver, input bit gaps, input bit corrupt);
    int wb, rb, nw, nr, t;
    logic [31:0] w, sum;
    wb = wr_addr_q.size();
    rb = rd_addr_q.size();
    acc_q.delete();
    corrupt_en = corrupt;
    @(negedge clk);
    start = 1'b1; word_count = CW'(n); verify_en = ver;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL load_start busy=%0b error=%0b want busy=1 error=0", busy, error);
    end
    for (int i = 0; i < pat.size(); i++) begin
      send_byte(pat[i], gaps);
      if (i % 4 == 3) acc_q.push_back(last_acc);
    end
    t = 0;
    while (done !== 1'b1 && t < 4 * n + 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL load_done got done=%0b want 1 within bound", done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL done_busy got busy=%0b want 0", busy);
    end
    sum = '0;
    for (int i = 0; i < n; i++) sum += {pat[4*i+3], pat[4*i+2], pat[4*i+1], pat[4*i]};
    nw = wr_addr_q.size() - wb;
    checks++;
    if (nw != n) begin
      errors++; $display("FAIL write_count got %0d want %0d", nw, n);
    end
    for (int i = 0; i < n && i < nw; i++) begin
      w = {pat[4*i+3], pat[4*i+2], pat[4*i+1], pat[4*i]};
      checks++;
      if (wr_addr_q[wb+i] != i || wr_data_q[wb+i] !== w) begin
        errors++;
        $display("FAIL write_%0d got %h@%0d want %h@%0d", i, wr_data_q[wb+i], wr_addr_q[wb+i], w, i);
      end
      checks++;
      if (wr_cyc_q[wb+i] != acc_q[i] + 1 || wr_rdy_q[wb+i] !== 1'b0) begin
        errors++;
        $display("FAIL write_timing_%0d got cycle %0d in_ready=%0b want cycle %0d in_ready=0",
                 i, wr_cyc_q[wb+i], wr_rdy_q[wb+i], acc_q[i] + 1);
      end
    end
    checks++;
    if (checksum !== sum) begin
      errors++; $display("FAIL checksum got %h want %h", checksum, sum);
    end
    checks++;
    if (words_written !== CW'(n)) begin
      errors++; $display("FAIL words_written got %0d want %0d", words_written, n);
    end
    checks++;
    if (error !== (ver && corrupt)) begin
      errors++; $display("FAIL error_flag got %0b want %0b", error, ver && corrupt);
    end
    if (ver) begin
      nr = rd_addr_q.size() - rb;
      checks++;
      if (nr != n) begin
        errors++; $display("FAIL read_count got %0d want %0d", nr, n);
      end
      for (int i = 0; i < n && i < nr; i++) begin
        checks++;
        if (rd_addr_q[rb+i] != i || (i > 0 && rd_cyc_q[rb+i] - rd_cyc_q[rb+i-1] != 2)) begin
          errors++;
          $display("FAIL read_%0d got addr %0d want %0d (2-cycle spacing)", i, rd_addr_q[rb+i], i);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse got done=%0b want 0 after one cycle", done);
    end
  endtask

  task automatic fill_spec_pattern();
    pat.delete();
    for (int i = 1; i <= 8; i++) pat.push_back(8'(8'h11 * i));
  endtask

  task automatic fill_random(input int n);
    pat.delete();
    for (int i = 0; i < 4 * n; i++) pat.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; word_count = '0; verify_en = 1'b0;
    in_data = '0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({chipselect, write, in_ready, busy, done, error} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 000000",
                         {chipselect, write, in_ready, busy, done, error});
    end
    checks++;
    if (byteenable !== 4'hF || address !== '0 || writedata !== '0) begin
      errors++; $display("FAIL reset_bus be=%h addr=%0d wd=%h want F/0/0", byteenable, address, writedata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (checksum !== '0 || words_written !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_status sum=%h ww=%0d busy=%0b want 0/0/0", checksum, words_written, busy);
    end
  endtask

  task automatic test_basic();
    fill_spec_pattern();
    do_load(2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (checksum !== 32'hCCAA8866) begin
      errors++; $display("FAIL basic_checksum got %h want CCAA8866", checksum);
    end
  endtask

  task automatic test_verify();
    fill_spec_pattern();
    do_load(2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_verify_corrupt();
    fill_spec_pattern();
    do_load(2, 1'b1, 1'b0, 1'b1);
    corrupt_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL error_sticky got %0b want 1", error);
    end
  endtask

  task automatic test_invalid();
    int c0, t;
    for (int k = 0; k < 2; k++) begin
      c0 = cs_count;
      @(negedge clk);
      start = 1'b1; word_count = (k == 0) ? CW'(0) : CW'(NW + 1); verify_en = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (done !== 1'b1 && t < 2) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL invalid_%0d done=%0b error=%0b busy=%0b want 1/1/0", k, done, error, busy);
      end
      @(negedge clk);
      checks++;
      if (cs_count != c0) begin
        errors++; $display("FAIL invalid_%0d_access got %0d chipselect cycles want 0", k, cs_count - c0);
      end
    end
  endtask

  task automatic test_gaps();
    fill_spec_pattern();
    do_load(2, 1'b0, 1'b1, 1'b0);
    checks++;
    if (mem[0] !== 32'h44332211 || mem[1] !== 32'h88776655) begin
      errors++; $display("FAIL gaps_mem got %h %h want 44332211 88776655", mem[0], mem[1]);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      fill_random(n);
      do_load(n, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_max_length();
    fill_random(NW);
    do_load(NW, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int t;
    pat.delete();
    for (int i = 1; i <= 8; i++) pat.push_back(8'(i));
    @(negedge clk);
    start = 1'b1; word_count = CW'(2); verify_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(pat[i], 1'b0);
    checks++;
    if (chipselect !== 1'b1 || write !== 1'b1) begin
      errors++; $display("FAIL mid_write_strobe got cs=%0b wr=%0b want 1/1", chipselect, write);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (chipselect !== 1'b0 || write !== 1'b0) begin
      errors++; $display("FAIL async_strobe_drop got cs=%0b wr=%0b want 0/0", chipselect, write);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1; word_count = CW'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(pat[i], 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({chipselect, write, in_ready, busy, done} !== 5'b0 || words_written !== '0 ||
        checksum !== '0 || address !== '0 || writedata !== '0 || byteenable !== 4'hF) begin
      errors++; $display("FAIL mid_reset_outputs cs=%0b wr=%0b rdy=%0b busy=%0b ww=%0d sum=%h addr=%0d wd=%h want reset values",
                         chipselect, write, in_ready, busy, words_written, checksum, address, writedata);
    end
    @(negedge clk);
    reset = 1'b0;
    t = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) t++;
    end
    checks++;
    if (t != 0) begin
      errors++; $display("FAIL mid_reset_done got %0d done cycles want 0", t);
    end
    pat.delete();
    pat.push_back(8'hAA); pat.push_back(8'hBB); pat.push_back(8'hCC); pat.push_back(8'hDD);
    do_load(1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mem[0] !== 32'hDDCCBBAA) begin
      errors++; $display("FAIL reload_mem got %h want DDCCBBAA", mem[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_verify();
    test_verify_corrupt();
    test_invalid();
    test_gaps();
    test_random();
    test_reset_mid();
    test_max_length();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
